// File: rtl/song_note_memory.sv
// Multi-slot writable note store: record notes by appending to a slot, play them back one per read_en.
// One read pointer is shared by all slots; changing slot_sel rewinds playback.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | rewound; the next read issues note 0 if the slot has any notes
//   PLAYING  | rd_ptr indexes the next note to issue
//   FINISHED | last note issued; resumes only if notes were appended since
module song_note_memory #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 32,
    parameter int SONGS      = 4,
    localparam int PTR_W     = $clog2(DEPTH) + 1,
    localparam int SLOT_W    = (SONGS > 1) ? $clog2(SONGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SLOT_W-1:0]     slot_sel,
    input  logic                  clear,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    input  logic                  read_rst,
    input  logic                  loop_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_ready,
    output logic                  play_done,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_W-1:0]      note_count
);

    localparam int ADDR_W = $clog2(SONGS * DEPTH);
    localparam logic [SLOT_W-1:0] SLOT_MASK = SLOT_W'(SONGS - 1);
    localparam logic [PTR_W-1:0]  DEPTH_P   = PTR_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, PLAYING, FINISHED} state_t;

    logic [DATA_WIDTH-1:0] mem [SONGS*DEPTH];
    logic [PTR_W-1:0]      count [SONGS];
    logic [PTR_W-1:0]      rd_ptr;
    logic [SLOT_W-1:0]     last_slot;
    state_t                state;

    logic [SLOT_W-1:0]     slot;
    logic [PTR_W-1:0]      cur_count;
    logic [PTR_W-1:0]      rd_idx;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  slot_change;
    logic                  wr_fire;

    always_comb begin
        // Masking keeps out-of-range selects inside the arrays when SONGS == 1
        slot        = slot_sel & SLOT_MASK;
        cur_count   = count[slot];
        slot_change = (slot != last_slot);
        rd_idx      = (state == IDLE) ? '0 : rd_ptr;
        rd_addr     = ADDR_W'({slot, rd_idx[PTR_W-2:0]});
        wr_addr     = ADDR_W'({slot, cur_count[PTR_W-2:0]});
        wr_fire     = !slot_change && !clear && write_en && (cur_count < DEPTH_P);
    end

    assign note_count = cur_count;
    assign full       = (cur_count == DEPTH_P);
    assign empty      = (cur_count == '0);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SONGS; s++) begin
                count[s] <= '0;
            end
            rd_ptr       <= '0;
            last_slot    <= '0;
            state        <= IDLE;
            data_out     <= '0;
            output_ready <= 1'b0;
            play_done    <= 1'b0;
        end else begin
            output_ready <= 1'b0;
            play_done    <= 1'b0;
            if (slot_change) begin
                last_slot <= slot;
                rd_ptr    <= '0;
                state     <= IDLE;
                data_out  <= '0;
            end else if (clear) begin
                count[slot] <= '0;
                rd_ptr      <= '0;
                state       <= IDLE;
            end else if (write_en) begin
                if (wr_fire) begin
                    count[slot] <= cur_count + 1'b1;
                end
            end else if (read_rst) begin
                rd_ptr   <= '0;
                state    <= IDLE;
                data_out <= '0;
            end else if (read_en && (rd_idx < cur_count)) begin
                data_out     <= mem[rd_addr];
                output_ready <= 1'b1;
                if ((rd_idx + 1'b1) < cur_count) begin
                    rd_ptr <= rd_idx + 1'b1;
                    state  <= PLAYING;
                end else if (loop_en) begin
                    rd_ptr <= '0;
                    state  <= PLAYING;
                end else begin
                    rd_ptr    <= cur_count;
                    play_done <= 1'b1;
                    state     <= FINISHED;
                end
            end
        end
    end

endmodule

// File: tb/tb_song_note_memory.sv
// Directed bench for song_note_memory: record, play once, loop, overflow, slot switch, clear, async reset.
module tb_song_note_memory;

    localparam int DW     = 10;
    localparam int DEPTH  = 32;
    localparam int SONGS  = 4;
    localparam int PTR_W  = 6;
    localparam int SLOT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [SLOT_W-1:0] slot_sel;
    logic              clear;
    logic              write_en;
    logic [DW-1:0]     data_in;
    logic              read_en;
    logic              read_rst;
    logic              loop_en;
    logic [DW-1:0]     data_out;
    logic              output_ready;
    logic              play_done;
    logic              full;
    logic              empty;
    logic [PTR_W-1:0]  note_count;

    int total = 0;
    int bad   = 0;

    song_note_memory #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SONGS(SONGS)) dut (
        .clk(clk), .rst_n(rst_n), .slot_sel(slot_sel), .clear(clear),
        .write_en(write_en), .data_in(data_in), .read_en(read_en),
        .read_rst(read_rst), .loop_en(loop_en), .data_out(data_out),
        .output_ready(output_ready), .play_done(play_done), .full(full),
        .empty(empty), .note_count(note_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic select_slot(input logic [SLOT_W-1:0] s);
        slot_sel = s;
        tick();
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        write_en = 1'b1;
        data_in  = d;
        tick();
        write_en = 1'b0;
    endtask

    task automatic do_read_rst();
        read_rst = 1'b1;
        tick();
        read_rst = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; slot_sel = '0; clear = 0; write_en = 0; data_in = '0;
        read_en = 0; read_rst = 0; loop_en = 0;
        repeat (3) tick();
        total++; if (data_out !== 10'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", data_out); end
        total++; if (output_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", output_ready); end
        total++; if (play_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", play_done); end
        total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b exp 1 0", empty, full); end
        total++; if (note_count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", note_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_play_once();
        logic [DW-1:0] exp_d [4] = '{10'h004, 10'h040, 10'h080, 10'h080};
        logic          exp_r [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic          exp_p [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        select_slot(2'd1);
        do_write(10'h004);
        do_write(10'h040);
        do_write(10'h080);
        total++; if (note_count !== 6'd3) begin bad++; $display("FAIL once_count got=%0d exp=3", note_count); end
        read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (output_ready !== exp_r[i]) begin bad++; $display("FAIL once_ready[%0d] got=%b exp=%b", i, output_ready, exp_r[i]); end
            total++; if (data_out !== exp_d[i]) begin bad++; $display("FAIL once_data[%0d] got=%h exp=%h", i, data_out, exp_d[i]); end
            total++; if (play_done !== exp_p[i]) begin bad++; $display("FAIL once_done[%0d] got=%b exp=%b", i, play_done, exp_p[i]); end
        end
        read_en = 1'b0;
        tick();
        total++; if (output_ready !== 1'b0) begin bad++; $display("FAIL once_idle_ready got=%b exp=0", output_ready); end
    endtask

    task automatic test_loop();
        logic [DW-1:0] notes [3] = '{10'h004, 10'h040, 10'h080};
        do_read_rst();
        total++; if (data_out !== 10'h000) begin bad++; $display("FAIL loop_rst_data got=%h exp=000", data_out); end
        loop_en = 1'b1;
        read_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++; if (output_ready !== 1'b1) begin bad++; $display("FAIL loop_ready[%0d] got=%b exp=1", i, output_ready); end
            total++; if (data_out !== notes[i % 3]) begin bad++; $display("FAIL loop_data[%0d] got=%h exp=%h", i, data_out, notes[i % 3]); end
            total++; if (play_done !== 1'b0) begin bad++; $display("FAIL loop_done[%0d] got=%b exp=0", i, play_done); end
        end
        read_en = 1'b0;
        loop_en = 1'b0;
    endtask

    task automatic test_write_during_play();
        do_read_rst();
        read_en = 1'b1;
        tick();
        total++; if (data_out !== 10'h004 || output_ready !== 1'b1) begin bad++; $display("FAIL wdp_first got=%h/%b exp=004/1", data_out, output_ready); end
        tick();
        total++; if (data_out !== 10'h040 || output_ready !== 1'b1) begin bad++; $display("FAIL wdp_second got=%h/%b exp=040/1", data_out, output_ready); end
        write_en = 1'b1;
        data_in  = 10'h200;
        tick();
        write_en = 1'b0;
        total++; if (output_ready !== 1'b0) begin bad++; $display("FAIL wdp_collide_ready got=%b exp=0", output_ready); end
        total++; if (note_count !== 6'd4) begin bad++; $display("FAIL wdp_count got=%0d exp=4", note_count); end
        total++; if (data_out !== 10'h040) begin bad++; $display("FAIL wdp_hold got=%h exp=040", data_out); end
        tick();
        total++; if (data_out !== 10'h080 || output_ready !== 1'b1 || play_done !== 1'b0) begin bad++; $display("FAIL wdp_third got=%h/%b/%b exp=080/1/0", data_out, output_ready, play_done); end
        tick();
        total++; if (data_out !== 10'h200 || output_ready !== 1'b1 || play_done !== 1'b1) begin bad++; $display("FAIL wdp_new got=%h/%b/%b exp=200/1/1", data_out, output_ready, play_done); end
        read_en = 1'b0;
    endtask

    task automatic test_full();
        select_slot(2'd0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            do_write(DW'(i + 1));
            if (i == DEPTH - 2) begin
                total++; if (full !== 1'b0) begin bad++; $display("FAIL full_early got=%b exp=0 after %0d writes", full, i + 1); end
            end
            if (i == DEPTH - 1) begin
                total++; if (full !== 1'b1) begin bad++; $display("FAIL full_at_depth got=%b exp=1", full); end
            end
        end
        total++; if (note_count !== 6'd32 || full !== 1'b1 || empty !== 1'b0) begin bad++; $display("FAIL full_final got count=%0d full=%b empty=%b exp 32 1 0", note_count, full, empty); end
        read_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            total++; if (data_out !== DW'(i + 1) || output_ready !== 1'b1) begin bad++; $display("FAIL full_read[%0d] got=%h/%b exp=%h/1", i, data_out, output_ready, DW'(i + 1)); end
            total++; if (play_done !== (i == DEPTH - 1)) begin bad++; $display("FAIL full_done[%0d] got=%b exp=%b", i, play_done, (i == DEPTH - 1)); end
        end
        tick();
        total++; if (output_ready !== 1'b0) begin bad++; $display("FAIL full_past_end got=%b exp=0", output_ready); end
        read_en = 1'b0;
    endtask

    task automatic test_slot_switch();
        select_slot(2'd2);
        total++; if (empty !== 1'b1 || note_count !== 6'd0) begin bad++; $display("FAIL sw_empty got empty=%b count=%0d exp 1 0", empty, note_count); end
        read_en = 1'b1;
        repeat (2) begin
            tick();
            total++; if (output_ready !== 1'b0) begin bad++; $display("FAIL sw_empty_read got=%b exp=0", output_ready); end
        end
        read_en = 1'b0;
        do_write(10'h101);
        select_slot(2'd1);
        do_read_rst();
        read_en = 1'b1;
        tick();
        total++; if (data_out !== 10'h004 || output_ready !== 1'b1) begin bad++; $display("FAIL sw_slot1 got=%h/%b exp=004/1", data_out, output_ready); end
        slot_sel = 2'd2;
        tick();
        total++; if (output_ready !== 1'b0 || data_out !== 10'h000) begin bad++; $display("FAIL sw_switch got=%h/%b exp=000/0", data_out, output_ready); end
        tick();
        total++; if (data_out !== 10'h101 || output_ready !== 1'b1 || play_done !== 1'b1) begin bad++; $display("FAIL sw_slot2 got=%h/%b/%b exp=101/1/1", data_out, output_ready, play_done); end
        read_en = 1'b0;
    endtask

    task automatic test_clear();
        do_write(10'h102);
        do_read_rst();
        read_en = 1'b1;
        tick();
        total++; if (data_out !== 10'h101 || output_ready !== 1'b1) begin bad++; $display("FAIL clr_pre got=%h/%b exp=101/1", data_out, output_ready); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (output_ready !== 1'b0 || note_count !== 6'd0 || empty !== 1'b1) begin bad++; $display("FAIL clr_abort got ready=%b count=%0d empty=%b exp 0 0 1", output_ready, note_count, empty); end
        tick();
        total++; if (output_ready !== 1'b0) begin bad++; $display("FAIL clr_after got=%b exp=0", output_ready); end
        read_en = 1'b0;
        do_write(10'h155);
        loop_en = 1'b1;
        read_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (data_out !== 10'h155 || output_ready !== 1'b1 || play_done !== 1'b0) begin bad++; $display("FAIL single_loop[%0d] got=%h/%b/%b exp=155/1/0", i, data_out, output_ready, play_done); end
        end
    endtask

    task automatic test_async_reset();
        tick();
        total++; if (output_ready !== 1'b1 || note_count !== 6'd1) begin bad++; $display("FAIL ar_pre got ready=%b count=%0d exp 1 1", output_ready, note_count); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (data_out !== 10'h000) begin bad++; $display("FAIL ar_data got=%h exp=000", data_out); end
        total++; if (output_ready !== 1'b0) begin bad++; $display("FAIL ar_ready got=%b exp=0", output_ready); end
        total++; if (note_count !== 6'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", note_count); end
        read_en = 1'b0;
        loop_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_play_once();
        test_loop();
        test_write_during_play();
        test_full();
        test_slot_switch();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/song_note_memory.md
Name: song_note_memory

Overview:
- Parametrised, writable successor to the fixed single-song note ROM. Stores up to SONGS independent note sequences; each is recorded by appending notes and played back one note per read_en.
- Sits between the keyboard/record front end and the playback/tone generator. Adds per-slot recording, clearing, loop playback and status flags.

Parameters:
- DATA_WIDTH, 10, width of one note word (note one-hot plus octave bits).
- DEPTH, 32, maximum notes per slot. Must be a power of 2 and at least 2.
- SONGS, 4, number of song slots. Must be a power of 2 and at least 1.
- Derived, not overridable: PTR_W = clog2(DEPTH)+1; SLOT_W = max(1, clog2(SONGS)).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- slot_sel  in  SLOT_W  selected song slot for every operation.
- clear  in  1  empty the selected slot.
- write_en  in  1  append data_in to the selected slot.
- data_in  in  DATA_WIDTH  note to append.
- read_en  in  1  request the next note of the selected slot.
- read_rst  in  1  rewind playback to note 0.
- loop_en  in  1  wrap to note 0 after the last note instead of finishing.
- data_out  out  DATA_WIDTH  registered note output.
- output_ready  out  1  data_out holds a new valid note this cycle.
- play_done  out  1  one-cycle pulse when a non-looping playback finishes.
- full  out  1  selected slot count == DEPTH (combinational from count).
- empty  out  1  selected slot count == 0 (combinational).
- note_count  out  PTR_W  count of the selected slot (combinational).

Behaviour:
- Storage:
  - Memory is SONGS*DEPTH words at address {slot, index}; contents are not reset.
  - Per-slot counters count[s] range 0..DEPTH.
  - There is one read pointer, rd_ptr (PTR_W bits), and a registered copy last_slot.
- Reset (async, rst_n=0):
  - all count[s]=0, rd_ptr=0, last_slot=0, state=IDLE.
  - data_out=0, output_ready=0, play_done=0.
- Operation priority per cycle: clear > write_en > read_rst > read_en. Only the highest-priority asserted operation acts.
- Every cycle not performing a read: output_ready=0, play_done=0, data_out holds its value.
- Slot change:
  - If slot_sel != last_slot, the cycle acts as read_rst and the asserted operation is ignored.
  - last_slot is updated to slot_sel.
  - rd_ptr=0 and state=IDLE.
- clear: count[slot_sel]=0, rd_ptr=0, state=IDLE.
- write_en:
  - If count < DEPTH: mem[slot][count] <= data_in and count++.
  - If full: write is dropped and count is unchanged.
  - Playback state and rd_ptr are unaffected.
- read_rst: rd_ptr=0, state=IDLE, data_out=0.
- State machine states: IDLE, PLAYING, FINISHED.
  - IDLE + read_en:
    - If count=0: stay IDLE, output_ready=0.
    - Otherwise: issue note 0 and go to PLAYING.
  - PLAYING + read_en, issuing mem[slot][rd_ptr]:
    - Output: data_out <= that word and output_ready=1 on the next clock edge (1-cycle latency).
    - If rd_ptr+1 < count: rd_ptr++.
    - Else if loop_en: rd_ptr=0, stay PLAYING, no play_done.
    - Else: rd_ptr=count, play_done=1 in the same cycle as the last output_ready, go to FINISHED.
  - FINISHED + read_en:
    - If rd_ptr < count (notes appended since finishing): issue the note and return to PLAYING.
    - Otherwise: output_ready=0.
- Boundaries:
  - A write to the slot during playback extends the song without disturbing rd_ptr.
  - clear during playback aborts to IDLE. The next output_ready is 0 until a new write.
  - Reset mid-playback forces all outputs to 0 immediately, without waiting for a clock edge.
  - A single-note song with loop_en=1 outputs the same note on every read_en.

Test Plan:
- Reset, then write notes 0x004, 0x040, 0x080 to slot 1; issue 4 consecutive read_en. Expect data_out 0x004, 0x040, 0x080, each with output_ready=1 one cycle after its read_en. play_done pulses with 0x080. The 4th read gives output_ready=0. note_count=3.
- Same slot with loop_en=1 and 7 read_en. Expect the sequence 004, 040, 080, 004, 040, 080, 004 with no play_done.
- Write DEPTH+2 notes to slot 0. Expect full=1 after DEPTH writes and count=DEPTH; the last two writes are dropped; playback returns exactly the first DEPTH words.
- Read 2 notes of slot 1, then assert write_en and read_en together. Expect the write to occur, output_ready=0, and count=4. The next read_en returns the 3rd note; the 4th read returns the new note.
- Switch slot_sel 1→2 mid-playback while read_en is held. Expect output_ready=0 in the switch cycle, then slot 2 note 0. Empty slot 2 gives empty=1 and output_ready stays 0.
- Deassert rst_n asynchronously while output_ready=1. Expect data_out=0, output_ready=0, note_count=0 before the next clock edge.
